// File: rtl/mix_pkg.sv
// Shared definitions for the MIX card reader: word geometry, character codes,
// controller states and the ASCII to MIX character translation.
package mix_pkg;

  localparam int CHARS_PER_WORD = 5;
  localparam int MIX_ADDR_W     = 12;
  localparam int MIX_WORD_W     = 30;
  localparam int MIX_CHAR_W     = 6;

  localparam logic [MIX_CHAR_W-1:0] MIX_SPACE  = 6'd0;
  localparam logic [MIX_CHAR_W-1:0] MIX_A      = 6'd1;
  localparam logic [MIX_CHAR_W-1:0] MIX_J      = 6'd11;
  localparam logic [MIX_CHAR_W-1:0] MIX_S      = 6'd22;
  localparam logic [MIX_CHAR_W-1:0] MIX_DIGIT0 = 6'd30;
  localparam logic [MIX_CHAR_W-1:0] MIX_PERIOD = 6'd40;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PAD,
    WRITE
  } state_t;

  typedef struct packed {
    logic                  is_cr;
    logic                  is_lf;
    logic [MIX_CHAR_W-1:0] code;
  } mix_char_t;

  // Lower case folds onto upper case; CR and LF are flagged rather than coded.
  function automatic mix_char_t ascii2mix(input logic [7:0] c);
    mix_char_t  r;
    logic [7:0] u;
    r = '0;
    u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
    if (c == 8'h0D) begin
      r.is_cr = 1'b1;
    end else if (c == 8'h0A) begin
      r.is_lf = 1'b1;
    end else if (u >= "A" && u <= "I") begin
      r.code = MIX_A + 6'(u - "A");
    end else if (u >= "J" && u <= "R") begin
      r.code = MIX_J + 6'(u - "J");
    end else if (u >= "S" && u <= "Z") begin
      r.code = MIX_S + 6'(u - "S");
    end else if (u >= "0" && u <= "9") begin
      r.code = MIX_DIGIT0 + 6'(u - "0");
    end else begin
      case (u)
        ".":     r.code = MIX_PERIOD;
        ",":     r.code = MIX_PERIOD + 6'd1;
        "(":     r.code = MIX_PERIOD + 6'd2;
        ")":     r.code = MIX_PERIOD + 6'd3;
        "+":     r.code = MIX_PERIOD + 6'd4;
        "-":     r.code = MIX_PERIOD + 6'd5;
        "*":     r.code = MIX_PERIOD + 6'd6;
        "/":     r.code = MIX_PERIOD + 6'd7;
        "=":     r.code = MIX_PERIOD + 6'd8;
        "$":     r.code = MIX_PERIOD + 6'd9;
        "<":     r.code = MIX_PERIOD + 6'd10;
        ">":     r.code = MIX_PERIOD + 6'd11;
        "@":     r.code = MIX_PERIOD + 6'd12;
        ";":     r.code = MIX_PERIOD + 6'd13;
        ":":     r.code = MIX_PERIOD + 6'd14;
        "'":     r.code = MIX_PERIOD + 6'd15;
        default: r.code = MIX_SPACE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver working on an already synchronized rx line.
// Emits one-cycle valid with the byte, or frame_err when the stop bit is low.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign data = shreg;

  // After a framing error the line may still be low; wait for idle before re-arming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx) begin
              valid <= 1'b1;
              state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mix_card_reader.sv
// MIX card reader: receives ASCII over UART, packs five MIX characters per word
// and writes a block of WORDS words to memory through a request/store handshake.
module mix_card_reader
  import mix_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int WORDS        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  start,
  input  logic [MIX_ADDR_W-1:0] addressin,
  output logic                  stop,
  output logic                  busy,
  output logic                  request,
  input  logic                  store,
  output logic [MIX_ADDR_W-1:0] addressout,
  output logic [MIX_WORD_W-1:0] out,
  output logic                  err
);

  localparam int WCW = $clog2(WORDS + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  localparam logic [2:0]     LAST_CHAR = 3'(CHARS_PER_WORD - 1);

  logic            rx_meta;
  logic            rx_sync;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ferr;

  state_t          state;
  logic [WCW-1:0]  word_cnt;
  logic [2:0]      char_cnt;
  logic            padding;
  logic            hold_full;
  logic [7:0]      hold_byte;
  mix_char_t       hold_char;
  logic            consume;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx_sync),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  assign hold_char = ascii2mix(hold_byte);
  assign consume   = (state == COLLECT) && hold_full;

  // The accumulator doubles as the out port: five 6-bit shifts flush a whole word,
  // so it never needs clearing between words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      request    <= 1'b0;
      stop       <= 1'b0;
      err        <= 1'b0;
      addressout <= '0;
      out        <= '0;
      word_cnt   <= '0;
      char_cnt   <= '0;
      padding    <= 1'b0;
      hold_full  <= 1'b0;
      hold_byte  <= '0;
    end else begin
      stop <= start;

      if (state == IDLE || padding) begin
        hold_full <= 1'b0;
      end else if (rx_valid) begin
        if (hold_full && !consume) begin
          err <= 1'b1;
        end else begin
          hold_byte <= rx_data;
          hold_full <= 1'b1;
        end
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      if (rx_ferr && state != IDLE) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            addressout <= addressin;
            err        <= 1'b0;
            busy       <= 1'b1;
            word_cnt   <= '0;
            char_cnt   <= '0;
            padding    <= 1'b0;
            out        <= '0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (hold_full) begin
            if (hold_char.is_lf) begin
              padding <= 1'b1;
              state   <= PAD;
            end else if (!hold_char.is_cr) begin
              out <= {out[MIX_WORD_W-MIX_CHAR_W-1:0], hold_char.code};
              if (char_cnt == LAST_CHAR) begin
                char_cnt <= '0;
                request  <= 1'b1;
                state    <= WRITE;
              end else begin
                char_cnt <= char_cnt + 3'd1;
              end
            end
          end
        end
        PAD: begin
          out <= {out[MIX_WORD_W-MIX_CHAR_W-1:0], MIX_SPACE};
          if (char_cnt == LAST_CHAR) begin
            char_cnt <= '0;
            request  <= 1'b1;
            state    <= WRITE;
          end else begin
            char_cnt <= char_cnt + 3'd1;
          end
        end
        WRITE: begin
          if (store) begin
            request    <= 1'b0;
            addressout <= addressout + MIX_ADDR_W'(1);
            word_cnt   <= word_cnt + WCW'(1);
            if (word_cnt == LAST_WORD) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= padding ? PAD : COLLECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
